// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MULT/MULTU/DIV/DIVU over the shared EX-stage ALU, owning HI/LO.
// Define MD_SIGNED_EN to build signed MULT/DIV (op[0]=1); otherwise every op is unsigned.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_ctr,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
    logic             r_div, r_dz, r_done;
    logic [WIDTH-1:0] w_rs_abs, w_rt_abs, w_shift, w_sum, w_rem, w_quo, w_rmd;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_dz, w_add, w_carry, w_ge;

    assign w_dz    = i_op[1] && (i_rt == '0);
    assign w_add   = r_acc_lo[0];
    assign w_shift = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
    // The bit shifted out of rem makes the true value exceed any divisor.
    assign w_ge    = r_acc_hi[WIDTH-1] || (w_shift >= r_opnd);
    assign w_carry = w_add && (i_alu_result < r_acc_hi);
    assign w_sum   = w_add ? i_alu_result : r_acc_hi;
    assign w_rem   = w_ge ? i_alu_result : w_shift;

    always_comb begin
        o_alu_ctr = (r_state != ITER) ? 3'd0 : r_div ? 3'd2 : w_add ? 3'd1 : 3'd0;
        o_alu_a   = (r_state != ITER) ? '0 : r_div ? w_shift : w_add ? r_acc_hi : '0;
        o_alu_b   = (o_alu_ctr != 3'd0) ? r_opnd : '0;
    end

`ifdef MD_SIGNED_EN
    logic r_neg_q, r_neg_r, w_neg_q, w_neg_r;
    assign w_rs_abs = (i_op[0] && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign w_rt_abs = (i_op[0] && i_rt[WIDTH-1]) ? -i_rt : i_rt;
    assign w_neg_q  = i_op[0] && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
    assign w_neg_r  = i_op[0] && i_rs[WIDTH-1];
    assign w_prod   = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quo    = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rmd    = r_neg_r ? -r_acc_hi : r_acc_hi;
`else
    logic w_unused_op0;
    assign w_unused_op0 = i_op[0];
    assign w_rs_abs = i_rs;
    assign w_rt_abs = i_rt;
    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_quo    = r_acc_lo;
    assign w_rmd    = r_acc_hi;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_div    <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MD_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state  <= w_dz ? FIX : ITER;
                        r_cnt    <= '0;
                        r_div    <= i_op[1];
                        r_dz     <= w_dz;
                        r_acc_hi <= '0;
                        // Divide-by-zero keeps raw rs here; FIX commits it to HI.
                        r_acc_lo <= w_dz ? i_rs : w_rs_abs;
                        r_opnd   <= w_rt_abs;
`ifdef MD_SIGNED_EN
                        r_neg_q  <= w_neg_q;
                        r_neg_r  <= w_neg_r;
`endif
                    end else begin
                        if (i_hi_we) r_hi <= i_wdata;
                        if (i_lo_we) r_lo <= i_wdata;
                    end
                end
                ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
                    if (r_div) begin
                        r_acc_hi <= w_rem;
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc_hi <= {w_carry, w_sum[WIDTH-1:1]};
                        r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    r_hi    <= r_dz ? r_acc_lo : r_div ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= r_dz ? '1 : r_div ? w_quo : w_prod[WIDTH-1:0];
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: vector table, hand-written corner sequences and randomized ops vs. an arithmetic model.
module tb_md_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0, rt = '0, wdata = '0;
    logic [31:0] alu_a, alu_b, alu_result, hi, lo;
    logic [2:0]  alu_ctr;
    logic        busy, done;
    int          checks = 0, errors = 0;
    logic        sgn_en;

    always #5 clk = ~clk;

    assign alu_result = (alu_ctr == 3'd1) ? alu_a + alu_b : (alu_ctr == 3'd2) ? alu_a - alu_b : 32'd0;

    md_sequencer #(.WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_op(op), .i_rs(rs), .i_rt(rt),
        .i_hi_we(hi_we), .i_lo_we(lo_we), .i_wdata(wdata),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctr(alu_ctr), .i_alu_result(alu_result),
        .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt, eh, el;
        int          lat;
        int          disturb;
        logic        wr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference results from plain arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic sg;
        sg = sgn_en && o[0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[1]) begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (sg) begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
        end
        if (sg) return 64'(sa * sb);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Starts an op at a negedge (caller must be idle or on the done cycle) and returns on the done cycle.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int exp_lat,
                         input int disturb, input logic wr);
        logic [31:0] ph, pl;
        int lat;
        logic sub;
        ph = hi; pl = lo; lat = 0; sub = 1'b0;
        op = o; rs = a; rt = b; start = 1'b1;
        if (wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A; end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({name, "_hi_held"}, hi, ph);
        chk({name, "_lo_held"}, lo, pl);
        chk({name, "_done_low"}, done, 0);
        while (busy && lat < 100) begin
            lat++;
            if (alu_ctr == 3'd2) sub = 1'b1;
            if (disturb > 0 && lat == disturb + 1) chk({name, "_lo_write_ignored"}, lo, pl);
            if (lat == disturb) begin
                start = 1'b1; op = ~o; rs = $urandom; rt = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00001234;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_done"}, done, 1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        if (o[1] && b == 32'd0) chk({name, "_no_sub"}, sub, 0);
    endtask

    vec_t vecs[10];
    logic [63:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        sgn_en = 1'b0;
`ifdef MD_SIGNED_EN
        sgn_en = 1'b1;
`endif
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 0, 1'b0};
        vecs[1] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'd2, sgn_en ? 32'hFFFFFFFF : 32'd1,
                    sgn_en ? 32'hFFFFFFFD : 32'h7FFFFFFC, 33, 0, 1'b0};
        vecs[3] = '{2'b01, 32'hFFFFFFFD, 32'd5, sgn_en ? 32'hFFFFFFFF : 32'd4, 32'hFFFFFFF1, 33, 0, 1'b0};
        vecs[4] = '{2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0, 1'b0};
        vecs[5] = '{2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1, 0, 1'b0};
        vecs[6] = '{2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 33, 5, 1'b0};
        vecs[7] = '{2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 33, 0, 1'b1};
        vecs[8] = '{2'b10, 32'd7, 32'hFFFFFFFF, 32'd7, 32'd0, 33, 0, 1'b0};
        vecs[9] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, sgn_en ? 32'd0 : 32'h80000000,
                    sgn_en ? 32'h80000000 : 32'd0, 33, 0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_alu_ctr", alu_ctr, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        hi_we = 1'b1; wdata = 32'h0000ABCD;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000ABCD);
        chk("mthi_lo_kept", lo, 0);
        lo_we = 1'b1; wdata = 32'h00005555;
        @(posedge clk);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h00005555);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].eh, vecs[i].el,
                  vecs[i].lat, vecs[i].disturb, vecs[i].wr);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_alu_ctr", alu_ctr, 0);
        chk("idle_alu_ab", {alu_a, alu_b}, 0);

        op = 2'b00; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_alu_ctr", alu_ctr, 0);
        chk("abort_done", done, 0);
        do_op("after_abort", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 33, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            exp = model(rop, ra, rb);
            do_op($sformatf("rand%0d", i), rop, ra, rb, exp[63:32], exp[31:0],
                  (rop[1] && rb == 32'd0) ? 1 : 33, 0, 1'b0);
        end
        @(negedge clk);
        chk("final_done_low", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. Implements MULT/MULTU/DIV/DIVU by time-sharing the EX-stage 32-bit ALU: it drives the ALU operands and ALU control code (0 = zero, 1 = add, 2 = sub) once per cycle, owns the HI/LO registers, and raises `busy` so hazard logic stalls dependent instructions.

## Interface
- `WIDTH`, 32, operand/ALU width and iteration count; must equal the ALU width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset).
- `start` in 1: one-cycle request to launch an operation; accepted only when `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs`, `rt` in 32: multiplicand/multiplier or dividend/divisor, sampled on the accepting edge.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write enables.
- `wdata` in 32: MTHI/MTLO data.
- `alu_a`, `alu_b` out 32: operands to the shared ALU.
- `alu_ctr` out 3: ALU control code (0, 1 or 2 only).
- `alu_result` in 32: ALU output, combinational return path.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse on the cycle after results commit.
- `hi`, `lo` out 32: architectural HI/LO.

## Operation
- States: IDLE, ITER, FIX.
- IDLE: `alu_ctr`=0, `alu_a`=`alu_b`=0, `busy`=0. On `start`=1, latch operands, record signs, go to ITER with count 0.
- Signed ops: latch absolute values of `rs`/`rt` (0x80000000 stays 0x80000000, treated as unsigned). Record `neg_q` = sign(rs) XOR sign(rt) and `neg_r` = sign(rs).
- MUL ITER: accumulator {acc_hi, acc_lo}, with acc_lo = multiplier.
  - If acc_lo[0]=1: `alu_ctr`=1, `alu_a`=acc_hi, `alu_b`=multiplicand. Carry = (`alu_result` < `alu_a`, unsigned).
  - Otherwise `alu_ctr`=0; the sum is acc_hi and carry is 0.
  - Next value: {carry, sum, acc_lo} >> 1.
- DIV ITER (restoring): shift {rem, quo} left by 1; msb = bit shifted out of rem.
  - `alu_ctr`=2, `alu_a`=shifted rem, `alu_b`=divisor.
  - If msb=1 or `alu_a` >= `alu_b` (unsigned): rem = `alu_result` and quo[0]=1. Otherwise rem is unchanged and quo[0]=0.
- ITER runs exactly WIDTH cycles, then goes to FIX.
- FIX: `alu_ctr`=0.
  - MUL: {hi, lo} = product, 64-bit two's-complement negated if signed and `neg_q`.
  - DIV: lo = quotient, negated if signed and `neg_q`; hi = remainder, negated if signed and `neg_r`.
  - Go to IDLE.
- Divide by zero (`rt`=0 with op DIVU or DIV): skip ITER; go directly to FIX; commit hi = raw `rs`, lo = 0xFFFFFFFF.
- MTHI/MTLO: when `busy`=0 and `start`=0, `hi_we`/`lo_we` write `wdata` at the edge. Writes are ignored while `busy`=1. If `start` and a write are asserted together, `start` wins and the write is dropped.
- `start` while `busy`=1 is ignored with no side effect.

## Timing
- Reset (reset=0 at an edge): state IDLE; `hi`=`lo`=0; `busy`=0; `done`=0; `alu_ctr`=0; `alu_a`=`alu_b`=0. Reset mid-operation aborts the operation and HI/LO are cleared.
- Accepting edge T: `busy`=1 from T+ onward.
- Normal operation: ITER on edges T+1..T+WIDTH; FIX commits `hi`/`lo` on edge T+WIDTH+1. `busy`=0 and `done`=1 for the following cycle. Latency is 33 cycles at WIDTH=32.
- Divide by zero: commit at edge T+1; `busy` is high for 1 cycle.
- A new `start` is accepted in the same cycle `done`=1.
- `alu_a`/`alu_b`/`alu_ctr` are combinational from the current state. `alu_result` is used within the same cycle.

## Configuration
- `MD_SIGNED_EN` defined: `op[0]`=1 selects signed MULT/DIV with the abs/negate handling above.
- `MD_SIGNED_EN` undefined: `op[0]` is ignored and every operation is unsigned; no sign/negation logic is built.

## Test plan
- MULTU with rs=rt=0xFFFFFFFF -> after 33 busy cycles: hi=0xFFFFFFFE, lo=0x00000001, `done` pulses once.
- DIVU 100/7 -> lo=14, hi=2. With `MD_SIGNED_EN`: DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- With `MD_SIGNED_EN`: MULT 0xFFFFFFFD (-3) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without it, the same stimulus gives hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 5/0 -> `busy` high 1 cycle, hi=0x00000005, lo=0xFFFFFFFF; `alu_ctr` never equals 2.
- MTLO 0x1234 while busy -> ignored, lo holds the operation result. MTHI 0xABCD when idle -> hi=0xABCD next cycle. `start` during busy -> no restart; latency unchanged.
- reset=0 at iteration 10 of a MULTU -> next cycle `busy`=0, `hi`=`lo`=0, `alu_ctr`=0. A subsequent MULTU 3×4 gives lo=12, hi=0.
